cry_rgb_conv: RTL

CRY_RGB_CONV -- requirements
Module: cry_rgb_conv

---
 rtl/cry_pkg.sv | 41 ++++
 rtl/cry_rgb_conv_if.sv | 27 ++
 rtl/cry_mul8.sv | 55 +++++
 rtl/cry_rgb_conv.sv | 133 +++++++++++++
 4 files changed

// File: rtl/cry_pkg.sv
// Shared definitions for the CRY-to-RGB pixel converter: FSM encoding,
// datapath widths, bus field offsets and the product scaling helper.
package cry_pkg;

    localparam int unsigned CH_W   = 8;   // one colour channel / intensity
    localparam int unsigned ITER_N = 8;   // shift-add steps per multiply
    localparam int unsigned CNT_W  = 3;   // holds 0..ITER_N-1
    localparam int unsigned ACC_W  = 16;  // full 8x8 product
    localparam int unsigned ADDR_W = 8;   // CRY colour ROM address
    localparam int unsigned CRY_W  = 16;
    localparam int unsigned RGB_W  = 24;

    // CRY pixel fields: intensity low byte, cyan/red nibbles form the ROM address
    localparam int unsigned CRY_Y_LSB    = 0;
    localparam int unsigned CRY_ADDR_LSB = 8;

    // RGB output fields
    localparam int unsigned RGB_B_LSB = 0;
    localparam int unsigned RGB_G_LSB = 8;
    localparam int unsigned RGB_R_LSB = 16;

    // Rounding bias; largest product 0xFE01 plus bias still fits in ACC_W
    localparam logic [ACC_W-1:0] ROUND_BIAS = ACC_W'(128);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_MUL,
        ST_DONE
    } state_e;

    // Scale a base*Y product back to channel range, optionally rounded
    function automatic logic [CH_W-1:0] scale_prod(input logic [ACC_W-1:0] prod,
                                                   input logic             rnd);
        logic [ACC_W-1:0] biased;
        biased = rnd ? (prod + ROUND_BIAS) : prod;
        return CH_W'(biased >> CH_W);
    endfunction

endpackage

// File: rtl/cry_rgb_conv_if.sv
// Pixel-in / ROM / pixel-out bundle of the CRY-to-RGB converter.
interface cry_rgb_conv_if;
    import cry_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [CRY_W-1:0]  cry;
    logic [ADDR_W-1:0] rom_a;
    logic              rom_clk;
    logic [CH_W-1:0]   rom_r;
    logic [CH_W-1:0]   rom_g;
    logic [CH_W-1:0]   rom_b;
    logic              out_valid;
    logic              out_ready;
    logic [RGB_W-1:0]  rgb;

    modport slave (
        input  in_valid, cry, rom_r, rom_g, rom_b, out_ready,
        output in_ready, rom_a, rom_clk, out_valid, rgb
    );

    modport master (
        output in_valid, cry, rom_r, rom_g, rom_b, out_ready,
        input  in_ready, rom_a, rom_clk, out_valid, rgb
    );

endinterface

// File: rtl/cry_mul8.sv
// One colour channel: serial 8x8 shift-add multiply, LSB of multiplier first.
// scaled_c_o reflects the accumulator value being written this cycle, so the
// final scaled product is available combinationally during the last step.
module cry_mul8
    import cry_pkg::*;
#(
    parameter bit ROUND = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [CH_W-1:0] base_i,
    input  logic [CH_W-1:0] mult_i,
    output logic [CH_W-1:0] scaled_c_o
);

    logic [ACC_W-1:0] mcand_q, mcand_d;
    logic [CH_W-1:0]  mplier_q, mplier_d;
    logic [ACC_W-1:0] acc_q, acc_d;

    // Load operands or perform one add-and-shift step
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (load_i) begin
            mcand_d  = ACC_W'(base_i);
            mplier_d = mult_i;
            acc_d    = '0;
        end else if (step_i) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    // Operand and accumulator registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    assign scaled_c_o = scale_prod(acc_d, ROUND);

endmodule

// File: rtl/cry_rgb_conv.sv
// CRY-to-RGB pixel converter: fetches the base colour for a CRY pixel from
// three external ROMs, scales each channel by the pixel intensity with a
// serial multiplier, and presents the RGB result on a valid/ready output.
module cry_rgb_conv
    import cry_pkg::*;
#(
    parameter bit ROUND = 1'b0
) (
    input  logic           sys_clk,
    input  logic           resetl,
    cry_rgb_conv_if.slave  bus
);

    state_e            state_q, state_d;
    logic [CH_W-1:0]   y_q, y_d;
    logic [ADDR_W-1:0] rom_a_q, rom_a_d;
    logic              rom_clk_q, rom_clk_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [RGB_W-1:0]  rgb_q, rgb_d;
    logic              load_c;
    logic              step_c;
    logic [CH_W-1:0]   r_c, g_c, b_c;

    // Next-state, datapath control and output register updates
    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        rom_a_d     = rom_a_q;
        rom_clk_d   = 1'b0;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        rgb_d       = rgb_q;
        load_c      = 1'b0;
        step_c      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    y_d       = bus.cry[CRY_Y_LSB +: CH_W];
                    rom_a_d   = bus.cry[CRY_ADDR_LSB +: ADDR_W];
                    rom_clk_d = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                load_c  = 1'b1;
                cnt_d   = '0;
                state_d = ST_MUL;
            end
            ST_MUL: begin
                step_c = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER_N - 1)) begin
                    rgb_d[RGB_R_LSB +: CH_W] = r_c;
                    rgb_d[RGB_G_LSB +: CH_W] = g_c;
                    rgb_d[RGB_B_LSB +: CH_W] = b_c;
                    out_valid_d              = 1'b1;
                    state_d                  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            state_q     <= ST_IDLE;
            y_q         <= '0;
            rom_a_q     <= '0;
            rom_clk_q   <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            rgb_q       <= '0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            rom_a_q     <= rom_a_d;
            rom_clk_q   <= rom_clk_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            rgb_q       <= rgb_d;
        end
    end

    cry_mul8 #(.ROUND(ROUND)) u_mul_r (
        .clk        (sys_clk),
        .rst_n      (resetl),
        .load_i     (load_c),
        .step_i     (step_c),
        .base_i     (bus.rom_r),
        .mult_i     (y_q),
        .scaled_c_o (r_c)
    );

    cry_mul8 #(.ROUND(ROUND)) u_mul_g (
        .clk        (sys_clk),
        .rst_n      (resetl),
        .load_i     (load_c),
        .step_i     (step_c),
        .base_i     (bus.rom_g),
        .mult_i     (y_q),
        .scaled_c_o (g_c)
    );

    cry_mul8 #(.ROUND(ROUND)) u_mul_b (
        .clk        (sys_clk),
        .rst_n      (resetl),
        .load_i     (load_c),
        .step_i     (step_c),
        .base_i     (bus.rom_b),
        .mult_i     (y_q),
        .scaled_c_o (b_c)
    );

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.rom_a     = rom_a_q;
    assign bus.rom_clk   = rom_clk_q;
    assign bus.out_valid = out_valid_q;
    assign bus.rgb       = rgb_q;

endmodule
